code_memory_loader: RTL and testbench

CODE_MEMORY_LOADER -- requirements
Module: code_memory_loader

---
 rtl/code_memory_loader_pkg.sv | 19 +
 rtl/code_memory_loader_byte_packer.sv | 33 +++
 rtl/code_memory_loader.sv | 157 +++++++++++++++
 tb/tb_code_memory_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_memory_loader_pkg.sv
// Shared constants and loader state encoding.
// Imported by every file of the code memory loader.
package code_memory_loader_pkg;

  localparam logic [31:0] BEGINNING_TEXT = 32'h0040_0000;
  localparam int          TEXT_WIDTH     = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    READ,
    WAIT,
    CMP,
    DONE,
    ERR
  } loaderState_t;

endpackage

// File: rtl/code_memory_loader_byte_packer.sv
// Packs source bytes little-endian into one code word.
// Ports: clk/rstN, clear, fire, byteData in; word, wordValid out.
module byte_packer
  import code_memory_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  clear,
  input  logic                  fire,
  input  logic [7:0]            byteData,
  output logic [TEXT_WIDTH-1:0] word,
  output logic                  wordValid
);

  logic [1:0] count;

  // Shifting in from the top leaves the first byte in [7:0].
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= 2'd0;
      word  <= '0;
    end else if (clear) begin
      count <= 2'd0;
      word  <= '0;
    end else if (fire) begin
      count <= count + 2'd1;
      word  <= {byteData, word[TEXT_WIDTH-1:8]};
    end
  end

  assign wordValid = fire && (count == 2'd3);

endmodule

// File: rtl/code_memory_loader.sv
// Loads a byte stream into code memory and verifies each word.
// Ports: byte source in, memory strobes/address/data, status flags.
module code_memory_loader
  import code_memory_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BEGINNING_TEXT,
  parameter int          MAX_WORDS = 4096,
  parameter int          READ_LAT  = 2
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iStart,
  input  logic [15:0]           iNumWords,
  input  logic                  iByteValid,
  input  logic [7:0]            iByteData,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic                  oReadEnable,
  output logic [3:0]            oByteEnable,
  output logic [31:0]           oAddress,
  output logic [TEXT_WIDTH-1:0] oWriteData,
  input  logic [TEXT_WIDTH-1:0] iReadData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError,
  output logic [31:0]           oErrAddr
);

  localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);
  localparam logic [31:0] OVER_ADDR = BASE_ADDR + (MAX_W << 2);
  localparam logic [7:0]  WAIT_LAST = 8'(READ_LAT - 2);

  // Assert passes straight through; release is retimed by two flops.
  logic rstMeta, rstN;
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rstMeta <= 1'b0;
      rstN    <= 1'b0;
    end else begin
      rstMeta <= 1'b1;
      rstN    <= rstMeta;
    end
  end

  loaderState_t state, nextState, startTarget;
  logic [15:0] index, numWords;
  logic [7:0]  waitCnt;
  logic [31:0] errAddr, curAddr;
  logic [TEXT_WIDTH-1:0] word;
  logic fire, wordValid, startOk, tooBig, lastWord, match;

  assign curAddr  = BASE_ADDR + 32'({index, 2'b00});
  assign fire     = iByteValid && oByteReady;
  assign tooBig   = {16'd0, iNumWords} > MAX_W;
  assign lastWord = index == (numWords - 16'd1);
  assign match    = iReadData == word;
  assign startOk  = iStart &&
                    (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    startTarget = COLLECT;
    if (iNumWords == 16'd0) startTarget = DONE;
    else if (tooBig)        startTarget = ERR;
  end

  byte_packer uPacker (
    .clk      (iCLK),
    .rstN     (rstN),
    .clear    (startOk),
    .fire     (fire),
    .byteData (iByteData),
    .word     (word),
    .wordValid(wordValid)
  );

  always_ff @(posedge iCLK or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    oByteReady   = 1'b0;
    oWriteEnable = 1'b0;
    oReadEnable  = 1'b0;
    oByteEnable  = 4'b0000;
    oAddress     = '0;
    oWriteData   = '0;
    oBusy        = 1'b0;
    oDone        = 1'b0;
    oError       = 1'b0;
    oErrAddr     = '0;
    unique case (state)
      IDLE, DONE, ERR: begin
        oDone  = state == DONE;
        oError = state == ERR;
        if (state == ERR) oErrAddr = errAddr;
        if (iStart) nextState = startTarget;
      end
      COLLECT: begin
        oBusy      = 1'b1;
        oByteReady = 1'b1;
        if (wordValid) nextState = WRITE;
      end
      WRITE: begin
        oBusy        = 1'b1;
        oWriteEnable = 1'b1;
        oByteEnable  = 4'b1111;
        oAddress     = curAddr;
        oWriteData   = word;
        nextState    = READ;
      end
      READ: begin
        oBusy       = 1'b1;
        oReadEnable = 1'b1;
        oByteEnable = 4'b1111;
        oAddress    = curAddr;
        nextState   = (READ_LAT > 1) ? WAIT : CMP;
      end
      WAIT: begin
        oBusy    = 1'b1;
        oAddress = curAddr;
        if (waitCnt == WAIT_LAST) nextState = CMP;
      end
      CMP: begin
        oBusy    = 1'b1;
        oAddress = curAddr;
        if (!match)       nextState = ERR;
        else if (lastWord) nextState = DONE;
        else              nextState = COLLECT;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge rstN) begin
    if (!rstN) begin
      index    <= '0;
      numWords <= '0;
      waitCnt  <= '0;
      errAddr  <= '0;
    end else begin
      if (startOk) begin
        index    <= '0;
        numWords <= iNumWords;
        if (tooBig) errAddr <= OVER_ADDR;
      end
      if (state == READ) waitCnt <= '0;
      if (state == WAIT) waitCnt <= waitCnt + 8'd1;
      if (state == CMP) begin
        if (!match)        errAddr <= curAddr;
        else if (!lastWord) index  <= index + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_code_memory_loader.sv
// Self-checking bench for code_memory_loader.
// Directed loads plus a randomized image against a reference model.
module tb_code_memory_loader;

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iNumWords = '0;
  logic        iByteValid = 1'b0;
  logic [7:0]  iByteData = '0;
  logic [31:0] iReadData = '0;
  logic        oByteReady, oWriteEnable, oReadEnable;
  logic [3:0]  oByteEnable;
  logic [31:0] oAddress, oWriteData, oErrAddr;
  logic        oBusy, oDone, oError;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  code_memory_loader dut (
    .iCLK        (iCLK),
    .iRSTn       (iRSTn),
    .iStart      (iStart),
    .iNumWords   (iNumWords),
    .iByteValid  (iByteValid),
    .iByteData   (iByteData),
    .oByteReady  (oByteReady),
    .oWriteEnable(oWriteEnable),
    .oReadEnable (oReadEnable),
    .oByteEnable (oByteEnable),
    .oAddress    (oAddress),
    .oWriteData  (oWriteData),
    .iReadData   (iReadData),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oError      (oError),
    .oErrAddr    (oErrAddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory with two-cycle read latency and optional corruption.
  logic [31:0] mem [0:255];
  logic [31:0] rdPipe = '0;
  int          corruptIdx = -1;
  logic [31:0] wrAddr[$], wrData[$], rdAddr[$];

  function automatic int slot(input logic [31:0] a);
    return int'((a - 32'h0040_0000) >> 2) & 255;
  endfunction

  always @(posedge iCLK) begin
    if (oWriteEnable) begin
      mem[slot(oAddress)] <= oWriteData;
      wrAddr.push_back(oAddress);
      wrData.push_back(oWriteData);
    end
    if (oReadEnable) begin
      rdAddr.push_back(oAddress);
      rdPipe <= mem[slot(oAddress)] ^
                ((slot(oAddress) == corruptIdx) ? 32'h0000_0100 : 32'h0);
    end
    iReadData <= rdPipe;
  end

  always @(negedge iCLK) begin
    if (iRSTn) begin
      chk("strobe_excl", {31'b0, oWriteEnable && oReadEnable}, 32'd0);
      chk("byte_enable", {28'b0, oByteEnable},
          (oWriteEnable || oReadEnable) ? 32'hF : 32'h0);
      if (oByteReady) chk("ready_busy", {31'b0, oBusy}, 32'd1);
    end
  end

  logic [7:0]  src[$];
  logic [31:0] expWord[$];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic buildExp();
    expWord.delete();
    for (int w = 0; w < src.size() / 4; w++)
      expWord.push_back({src[4*w+3], src[4*w+2], src[4*w+1], src[4*w]});
  endtask

  task automatic makeImage(input int n);
    src.delete();
    for (int i = 0; i < 4 * n; i++) src.push_back(8'($urandom));
    buildExp();
  endtask

  task automatic clearLogs();
    wrAddr.delete();
    wrData.delete();
    rdAddr.delete();
  endtask

  task automatic pulseStart(input logic [15:0] n);
    iNumWords = n;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int budget);
    int  k = 0;
    int  cyc = 0;
    bit  fire;
    while (k < src.size() && !oError && cyc < budget) begin
      iByteValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      iByteData  = src[k];
      @(negedge iCLK);
      fire = iByteValid && oByteReady;
      tick();
      if (fire) k++;
      cyc++;
    end
    iByteValid = 1'b0;
    if (!oError) chk("feed_bytes", 32'(k), 32'(src.size()));
  endtask

  task automatic waitEnd(input int budget);
    int cyc = 0;
    while (!oDone && !oError && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("finish_in_time", {31'b0, oDone || oError}, 32'd1);
  endtask

  task automatic runLoad(input int n, input bit gaps);
    clearLogs();
    pulseStart(16'(n));
    feed(gaps, 20000);
    waitEnd(200);
  endtask

  task automatic checkImage(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wrAddr.size()), 32'(n));
    chk({tag, "_nrd"}, 32'(rdAddr.size()), 32'(n));
    for (int w = 0; w < n; w++) begin
      if (w < wrAddr.size()) begin
        chk({tag, "_waddr"}, wrAddr[w], 32'h0040_0000 + 32'(4 * w));
        chk({tag, "_wdata"}, wrData[w], expWord[w]);
      end
      if (w < rdAddr.size())
        chk({tag, "_raddr"}, rdAddr[w], 32'h0040_0000 + 32'(4 * w));
      chk({tag, "_mem"}, mem[w], expWord[w]);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_ready"}, {31'b0, oByteReady}, 32'd0);
    chk({tag, "_we"}, {31'b0, oWriteEnable}, 32'd0);
    chk({tag, "_re"}, {31'b0, oReadEnable}, 32'd0);
    chk({tag, "_be"}, {28'b0, oByteEnable}, 32'd0);
    chk({tag, "_addr"}, oAddress, 32'd0);
    chk({tag, "_wdata"}, oWriteData, 32'd0);
    chk({tag, "_busy"}, {31'b0, oBusy}, 32'd0);
    chk({tag, "_done"}, {31'b0, oDone}, 32'd0);
    chk({tag, "_err"}, {31'b0, oError}, 32'd0);
    chk({tag, "_erraddr"}, oErrAddr, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;

    // Reset state
    tick();
    tick();
    chkAllZero("reset");
    iRSTn = 1'b1;
    repeat (4) tick();
    chkAllZero("idle");

    // Two-word load with known bytes
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    buildExp();
    runLoad(2, 1'b0);
    checkImage("two", 2);
    if (wrData.size() == 2) begin
      chk("two_w0", wrData[0], 32'h4433_2211);
      chk("two_w1", wrData[1], 32'h8877_6655);
    end
    chk("two_done", {31'b0, oDone}, 32'd1);
    chk("two_busy", {31'b0, oBusy}, 32'd0);
    chk("two_err", {31'b0, oError}, 32'd0);

    // Oversize image rejected from DONE
    clearLogs();
    pulseStart(16'd4097);
    chk("big_err", {31'b0, oError}, 32'd1);
    chk("big_erraddr", oErrAddr, 32'h0040_4000);
    chk("big_done", {31'b0, oDone}, 32'd0);
    chk("big_busy", {31'b0, oBusy}, 32'd0);
    repeat (5) tick();
    chk("big_nwr", 32'(wrAddr.size()), 32'd0);
    chk("big_nrd", 32'(rdAddr.size()), 32'd0);

    // Empty image from ERR
    clearLogs();
    pulseStart(16'd0);
    chk("zero_done", {31'b0, oDone}, 32'd1);
    chk("zero_err", {31'b0, oError}, 32'd0);
    chk("zero_erraddr", oErrAddr, 32'd0);
    repeat (5) tick();
    chk("zero_nwr", 32'(wrAddr.size()), 32'd0);
    chk("zero_nrd", 32'(rdAddr.size()), 32'd0);

    // Largest legal size is accepted, then abandoned by reset
    pulseStart(16'd4096);
    chk("max_busy", {31'b0, oBusy}, 32'd1);
    chk("max_ready", {31'b0, oByteReady}, 32'd1);
    chk("max_err", {31'b0, oError}, 32'd0);
    iRSTn = 1'b0;
    #1;
    chkAllZero("max_rst");
    tick();
    iRSTn = 1'b1;
    repeat (3) tick();

    // Read-back mismatch on word 1
    makeImage(3);
    corruptIdx = 1;
    runLoad(3, 1'b0);
    chk("bad_err", {31'b0, oError}, 32'd1);
    chk("bad_erraddr", oErrAddr, 32'h0040_0004);
    chk("bad_nwr", 32'(wrAddr.size()), 32'd2);
    repeat (10) tick();
    chk("bad_nwr_after", 32'(wrAddr.size()), 32'd2);
    chk("bad_busy", {31'b0, oBusy}, 32'd0);
    corruptIdx = -1;

    // Reset during WAIT of word 3
    makeImage(4);
    clearLogs();
    pulseStart(16'd6);
    feed(1'b0, 200);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 200) begin
      @(negedge iCLK);
      if (oReadEnable && oAddress == 32'h0040_000C) found = 1'b1;
      else cyc++;
    end
    chk("w3_read_seen", {31'b0, found}, 32'd1);
    @(posedge iCLK);
    #2;
    chk("w3_wait_busy", {31'b0, oBusy}, 32'd1);
    chk("w3_wait_addr", oAddress, 32'h0040_000C);
    iRSTn = 1'b0;
    #1;
    chkAllZero("midrst");
    tick();
    tick();
    iRSTn = 1'b1;
    repeat (3) tick();
    makeImage(2);
    runLoad(2, 1'b0);
    checkImage("reload", 2);
    chk("reload_done", {31'b0, oDone}, 32'd1);

    // 64 random words with source stalls
    makeImage(64);
    runLoad(64, 1'b1);
    checkImage("rand", 64);
    chk("rand_done", {31'b0, oDone}, 32'd1);
    chk("rand_busy", {31'b0, oBusy}, 32'd0);
    chk("rand_err", {31'b0, oError}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
